// File: rtl/multi_err_compare_block.sv
// Read-data compare stage: queues read-check commands, walks Avalon-MM read bursts
// word by word and reports mismatches of enabled bytes against a fixed or LFSR pattern.
module multi_err_compare_block #(
   parameter int DATA_W  = 128,
   parameter int ADDR_W  = 31,
   parameter int BURST_W = 8,
   parameter int FIFO_AW = 3,
   parameter int CNT_W   = 32,
   localparam int BYTES  = DATA_W / 8,
   localparam int BI_W   = $clog2(BYTES)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_test_i,
   input  logic                   stop_on_err_i,
   input  logic                   cmd_valid_i,
   output logic                   cmd_ready_o,
   input  logic [ADDR_W-1:0]      cmd_addr_i,
   input  logic [BURST_W-1:0]     cmd_words_i,
   input  logic [BI_W-1:0]        cmd_start_off_i,
   input  logic [BI_W-1:0]        cmd_end_off_i,
   input  logic [7:0]             cmd_data_i,
   input  logic                   cmd_rnd_i,
   input  logic                   readdatavalid_i,
   input  logic [DATA_W-1:0]      readdata_i,
   output logic                   err_stb_o,
   output logic [CNT_W-1:0]       err_cnt_o,
   output logic                   first_err_o,
   output logic [ADDR_W+BI_W-1:0] err_addr_o,
   output logic [7:0]             err_data_o,
   output logic [7:0]             orig_data_o,
   output logic                   orphan_o,
   output logic                   busy_o
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int PTR_W = FIFO_AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_HALT = 2'd3
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [BURST_W-1:0] words;
      logic [BI_W-1:0]    soff;
      logic [BI_W-1:0]    eoff;
      logic [7:0]         data;
      logic               rnd;
   } cmd_t;

   function automatic logic [7:0] lfsr_next(input logic [7:0] p);
      return {p[6:0], p[6] ^ p[1] ^ p[0]};
   endfunction

   function automatic logic [BI_W-1:0] lowest_set(input logic [BYTES-1:0] vec);
      logic [BI_W-1:0] idx;
      idx = {BI_W{1'b0}};
      for (int i = BYTES - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = BI_W'(i);
         end
      end
      return idx;
   endfunction

   cmd_t                   fifo_mem_q [DEPTH];
   cmd_t                   head_s, wr_cmd_s;
   state_t                 state_q, state_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]      addr_q, addr_d, s1_addr_q, s1_addr_d;
   logic [BURST_W-1:0]     words_q, words_d;
   logic [7:0]             pat_q, pat_d, s1_pat_q, s1_pat_d;
   logic [BI_W-1:0]        soff_q, soff_d, eoff_q, eoff_d, err_idx_s;
   logic                   rnd_q, rnd_d, first_q, first_d, stop_mode_q;
   logic                   s1_valid_q, s1_valid_d;
   logic [BYTES-1:0]       s1_mis_q, s1_mis_d, mis_s;
   logic [DATA_W-1:0]      s1_data_q, s1_data_d;
   logic                   err_stb_q, err_stb_d, first_err_q, first_err_d;
   logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
   logic [ADDR_W+BI_W-1:0] err_addr_q, err_addr_d;
   logic [7:0]             err_data_q, err_data_d, orig_data_q, orig_data_d;
   logic                   orphan_q, orphan_d, busy_q, busy_d, cmd_ready_q, cmd_ready_d;
   logic                   push_s, pop_s, fifo_empty_s, halt_now_s, halt_s;

   assign wr_cmd_s     = '{addr: cmd_addr_i, words: cmd_words_i, soff: cmd_start_off_i,
                           eoff: cmd_end_off_i, data: cmd_data_i, rnd: cmd_rnd_i};
   assign head_s       = fifo_mem_q[rd_ptr_q[FIFO_AW-1:0]];
   assign fifo_empty_s = (rd_ptr_q == wr_ptr_q);
   assign push_s       = cmd_valid_i && cmd_ready_q && !start_test_i && (state_q != ST_HALT);

   // Command storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         fifo_mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wr_cmd_s;
      end
   end

   // Per-byte mismatch of the incoming word; the first/last word masks apply at once on single-word bursts.
   always_comb begin
      mis_s = {BYTES{1'b0}};
      for (int i = 0; i < BYTES; i++) begin
         if ((first_q && (BI_W'(i) < soff_q)) ||
             ((words_q == {BURST_W{1'b0}}) && (BI_W'(i) > eoff_q))) begin
            mis_s[i] = 1'b0;
         end else begin
            mis_s[i] = (readdata_i[8*i +: 8] != pat_q);
         end
      end
   end

   // Stage 2: error strobe, saturating count and first-error capture.
   always_comb begin
      err_stb_d   = 1'b0;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      err_addr_d  = err_addr_q;
      err_data_d  = err_data_q;
      orig_data_d = orig_data_q;
      halt_now_s  = 1'b0;
      err_idx_s   = lowest_set(s1_mis_q);
      if (s1_valid_q && (|s1_mis_q) && (state_q != ST_HALT)) begin
         err_stb_d = 1'b1;
         if (err_cnt_q != {CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
         end else begin
            err_cnt_d = err_cnt_q;
         end
         if (!first_err_q) begin
            first_err_d = 1'b1;
            err_addr_d  = {s1_addr_q, err_idx_s};
            err_data_d  = s1_data_q[{err_idx_s, 3'b000} +: 8];
            orig_data_d = s1_pat_q;
         end else begin
            first_err_d = first_err_q;
         end
         halt_now_s = stop_mode_q;
      end else begin
         halt_now_s = 1'b0;
      end
   end

   // Burst tracking FSM, FIFO pointers and stage-1 capture.
   always_comb begin
      state_d    = state_q;
      rd_ptr_d   = rd_ptr_q;
      addr_d     = addr_q;
      words_d    = words_q;
      pat_d      = pat_q;
      soff_d     = soff_q;
      eoff_d     = eoff_q;
      rnd_d      = rnd_q;
      first_d    = first_q;
      s1_valid_d = 1'b0;
      s1_mis_d   = s1_mis_q;
      s1_addr_d  = s1_addr_q;
      s1_pat_d   = s1_pat_q;
      s1_data_d  = s1_data_q;
      orphan_d   = orphan_q;
      pop_s      = 1'b0;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      case (state_q)
         ST_IDLE: begin
            orphan_d = orphan_q | readdatavalid_i;
            if (!fifo_empty_s) begin
               pop_s   = 1'b1;
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            orphan_d = orphan_q | readdatavalid_i;
            state_d  = ST_RUN;
         end
         ST_RUN: begin
            if (readdatavalid_i) begin
               s1_valid_d = 1'b1;
               s1_mis_d   = mis_s;
               s1_addr_d  = addr_q;
               s1_pat_d   = pat_q;
               s1_data_d  = readdata_i;
               addr_d     = addr_q + ADDR_W'(1);
               words_d    = words_q - BURST_W'(1);
               first_d    = 1'b0;
               if (rnd_q) begin
                  pat_d = lfsr_next(pat_q);
               end else begin
                  pat_d = pat_q;
               end
               if (words_q == {BURST_W{1'b0}}) begin
                  if (!fifo_empty_s) begin
                     pop_s   = 1'b1;
                     state_d = ST_LOAD;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // A pop loads the working registers straight from the FIFO head; LOAD is the settle cycle.
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         addr_d   = head_s.addr;
         words_d  = head_s.words;
         pat_d    = head_s.data;
         soff_d   = head_s.soff;
         eoff_d   = head_s.eoff;
         rnd_d    = head_s.rnd;
         first_d  = 1'b1;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      halt_s      = halt_now_s || (state_q == ST_HALT);
      state_d     = halt_s ? ST_HALT : state_d;
      rd_ptr_d    = halt_s ? wr_ptr_d : rd_ptr_d;
      s1_valid_d  = halt_s ? 1'b0 : s1_valid_d;
      busy_d      = (state_d != ST_HALT) &&
                    ((wr_ptr_d != rd_ptr_d) || (state_d == ST_LOAD) ||
                     (state_d == ST_RUN) || s1_valid_d);
      cmd_ready_d = ((wr_ptr_d - rd_ptr_d) != PTR_W'(DEPTH));
   end

   // State register; start_test_i clears like reset but latches the stop mode.
   always_ff @(posedge clk_i) begin
      if (rst_i || start_test_i) begin
         state_q     <= ST_IDLE;
         rd_ptr_q    <= {PTR_W{1'b0}};
         wr_ptr_q    <= {PTR_W{1'b0}};
         addr_q      <= {ADDR_W{1'b0}};
         words_q     <= {BURST_W{1'b0}};
         pat_q       <= 8'h00;
         soff_q      <= {BI_W{1'b0}};
         eoff_q      <= {BI_W{1'b0}};
         rnd_q       <= 1'b0;
         first_q     <= 1'b0;
         stop_mode_q <= rst_i ? 1'b0 : stop_on_err_i;
         s1_valid_q  <= 1'b0;
         s1_mis_q    <= {BYTES{1'b0}};
         s1_addr_q   <= {ADDR_W{1'b0}};
         s1_pat_q    <= 8'h00;
         s1_data_q   <= {DATA_W{1'b0}};
         err_stb_q   <= 1'b0;
         err_cnt_q   <= {CNT_W{1'b0}};
         first_err_q <= 1'b0;
         err_addr_q  <= {(ADDR_W+BI_W){1'b0}};
         err_data_q  <= 8'h00;
         orig_data_q <= 8'h00;
         orphan_q    <= 1'b0;
         busy_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         addr_q      <= addr_d;
         words_q     <= words_d;
         pat_q       <= pat_d;
         soff_q      <= soff_d;
         eoff_q      <= eoff_d;
         rnd_q       <= rnd_d;
         first_q     <= first_d;
         stop_mode_q <= stop_mode_q;
         s1_valid_q  <= s1_valid_d;
         s1_mis_q    <= s1_mis_d;
         s1_addr_q   <= s1_addr_d;
         s1_pat_q    <= s1_pat_d;
         s1_data_q   <= s1_data_d;
         err_stb_q   <= err_stb_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         err_addr_q  <= err_addr_d;
         err_data_q  <= err_data_d;
         orig_data_q <= orig_data_d;
         orphan_q    <= orphan_d;
         busy_q      <= busy_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign err_stb_o   = err_stb_q;
   assign err_cnt_o   = err_cnt_q;
   assign first_err_o = first_err_q;
   assign err_addr_o  = err_addr_q;
   assign err_data_o  = err_data_q;
   assign orig_data_o = orig_data_q;
   assign orphan_o    = orphan_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_multi_err_compare_block.sv
// Directed bench for multi_err_compare_block: expected error events are queued by
// the stimulus and checked by a monitor whenever err_stb_o fires.
module tb_multi_err_compare_block;

   localparam int DW = 128;
   localparam int AW = 31;
   localparam int BW = 8;
   localparam int BIW = 4;
   localparam int CW = 32;

   logic            clk = 1'b0;
   logic            rst_i = 1'b1, start_test_i = 1'b0, stop_on_err_i = 1'b0;
   logic            cmd_valid_i = 1'b0, cmd_ready_o, cmd_rnd_i = 1'b0;
   logic [AW-1:0]   cmd_addr_i = '0;
   logic [BW-1:0]   cmd_words_i = '0;
   logic [BIW-1:0]  cmd_start_off_i = '0, cmd_end_off_i = '0;
   logic [7:0]      cmd_data_i = '0;
   logic            readdatavalid_i = 1'b0;
   logic [DW-1:0]   readdata_i = '0;
   logic            err_stb_o, first_err_o, orphan_o, busy_o;
   logic [CW-1:0]   err_cnt_o;
   logic [AW+BIW-1:0] err_addr_o;
   logic [7:0]      err_data_o, orig_data_o;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int                cnt;
      logic [AW+BIW-1:0] addr;
      logic [7:0]        data;
      logic [7:0]        orig;
   } exp_t;
   exp_t exp_q[$];

   multi_err_compare_block #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW), .FIFO_AW(3), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_test_i(start_test_i), .stop_on_err_i(stop_on_err_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
      .cmd_words_i(cmd_words_i), .cmd_start_off_i(cmd_start_off_i), .cmd_end_off_i(cmd_end_off_i),
      .cmd_data_i(cmd_data_i), .cmd_rnd_i(cmd_rnd_i), .readdatavalid_i(readdatavalid_i),
      .readdata_i(readdata_i), .err_stb_o(err_stb_o), .err_cnt_o(err_cnt_o),
      .first_err_o(first_err_o), .err_addr_o(err_addr_o), .err_data_o(err_data_o),
      .orig_data_o(orig_data_o), .orphan_o(orphan_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] fill(input logic [7:0] b);
      return {16{b}};
   endfunction

   task automatic expect_err(input int cnt, input logic [AW-1:0] waddr, input logic [BIW-1:0] bi,
                             input logic [7:0] data, input logic [7:0] orig);
      exp_t e;
      e.cnt = cnt; e.addr = {waddr, bi}; e.data = data; e.orig = orig;
      exp_q.push_back(e);
   endtask

   task automatic start_test(input logic stop);
      start_test_i = 1'b1; stop_on_err_i = stop;
      cyc();
      start_test_i = 1'b0; stop_on_err_i = 1'b0;
   endtask

   task automatic push_cmd(input logic [AW-1:0] a, input logic [BW-1:0] w, input logic [BIW-1:0] so,
                           input logic [BIW-1:0] eo, input logic [7:0] d, input logic r);
      cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_words_i = w;
      cmd_start_off_i = so; cmd_end_off_i = eo; cmd_data_i = d; cmd_rnd_i = r;
      cyc();
      cmd_valid_i = 1'b0;
   endtask

   task automatic rd_word(input logic [DW-1:0] d);
      readdatavalid_i = 1'b1; readdata_i = d;
      cyc();
      readdatavalid_i = 1'b0;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_err_stb"}, err_stb_o, 0);
      check({tag, "_err_cnt"}, err_cnt_o, 0);
      check({tag, "_first_err"}, first_err_o, 0);
      check({tag, "_err_addr"}, err_addr_o, 0);
      check({tag, "_err_data"}, err_data_o, 0);
      check({tag, "_orig_data"}, orig_data_o, 0);
      check({tag, "_orphan"}, orphan_o, 0);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_cmd_ready"}, cmd_ready_o, 1);
   endtask

   // Monitor: every error strobe consumes one queued expectation.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (err_stb_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_err_stb", err_stb_o, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("sb_err_cnt", err_cnt_o, e.cnt);
               check("sb_first_err", first_err_o, 1);
               check("sb_err_addr", err_addr_o, e.addr);
               check("sb_err_data", err_data_o, e.data);
               check("sb_orig_data", orig_data_o, e.orig);
            end
         end
      end
   end

   initial begin : stim
      logic [DW-1:0] d;
      cyc(); cyc();
      rst_i = 1'b0;
      check_cleared("reset");

      // T1: fixed 0xA5, four clean words
      start_test(1'b0);
      push_cmd(31'h100, 8'd3, 4'd0, 4'd15, 8'hA5, 1'b0);
      cyc(); cyc();
      for (int k = 0; k < 4; k++) rd_word(fill(8'hA5));
      check("t1_busy_n1", busy_o, 1);
      cyc();
      check("t1_busy_n2", busy_o, 0);
      check("t1_err_cnt", err_cnt_o, 0);

      // T2: byte 5 of word 2 corrupted, keep running
      start_test(1'b0);
      push_cmd(31'h100, 8'd3, 4'd0, 4'd15, 8'hA5, 1'b0);
      cyc(); cyc();
      expect_err(1, 31'h102, 4'd5, 8'h00, 8'hA5);
      for (int k = 0; k < 4; k++) begin
         d = fill(8'hA5);
         if (k == 2) d[47:40] = 8'h00;
         rd_word(d);
      end
      cyc(); cyc(); cyc();
      check("t2_err_cnt", err_cnt_o, 1);
      // T2b: second error counts, first-error capture stays put
      push_cmd(31'h180, 8'd0, 4'd0, 4'd15, 8'h3C, 1'b0);
      cyc(); cyc();
      expect_err(2, 31'h102, 4'd5, 8'h00, 8'hA5);
      rd_word(fill(8'h00));
      cyc(); cyc(); cyc();
      check("t2b_err_cnt", err_cnt_o, 2);

      // T3: LFSR seed 0x01 -> 0x01, 0x03, 0x06; bytes outside offsets corrupted
      start_test(1'b0);
      push_cmd(31'h200, 8'd2, 4'd3, 4'd9, 8'h01, 1'b1);
      cyc(); cyc();
      d = fill(8'h01);
      for (int j = 0; j < 3; j++) d[8*j +: 8] = 8'hFF;
      rd_word(d);
      rd_word(fill(8'h03));
      d = fill(8'h06);
      for (int j = 10; j < 16; j++) d[8*j +: 8] = 8'h00;
      rd_word(d);
      cyc(); cyc(); cyc();
      check("t3_err_cnt", err_cnt_o, 0);
      check("t3_first_err", first_err_o, 0);
      check("t3_busy", busy_o, 0);

      // T4: stop on first error with two commands queued
      start_test(1'b1);
      push_cmd(31'h300, 8'd2, 4'd0, 4'd15, 8'h5A, 1'b0);
      push_cmd(31'h310, 8'd0, 4'd0, 4'd15, 8'h5A, 1'b0);
      push_cmd(31'h320, 8'd0, 4'd0, 4'd15, 8'h5A, 1'b0);
      expect_err(1, 31'h300, 4'd0, 8'h00, 8'h5A);
      for (int k = 0; k < 3; k++) rd_word(fill(8'h00));
      cyc(); cyc(); cyc();
      check("t4_err_cnt", err_cnt_o, 1);
      check("t4_busy", busy_o, 0);
      check("t4_cmd_ready", cmd_ready_o, 1);
      check("t4_orphan", orphan_o, 0);
      rd_word(fill(8'h00));
      cyc(); cyc();
      check("t4_halt_orphan", orphan_o, 0);
      check("t4_halt_cnt", err_cnt_o, 1);
      check("t4_halt_busy", busy_o, 0);
      start_test(1'b0);
      check_cleared("t4_clear");

      // T5: fill the FIFO (one command is already active), then drain
      for (int i = 0; i < 9; i++) begin
         push_cmd(31'h400 + 31'(i), 8'd0, 4'd0, 4'd15, 8'h11, 1'b0);
         if (i == 7) check("t5_ready_after8", cmd_ready_o, 1);
         if (i == 8) check("t5_ready_after9", cmd_ready_o, 0);
      end
      rd_word(fill(8'h11));
      check("t5_ready_after_pop", cmd_ready_o, 1);
      for (int i = 0; i < 8; i++) begin
         cyc(); cyc();
         rd_word(fill(8'h11));
      end
      cyc(); cyc(); cyc();
      check("t5_busy", busy_o, 0);
      check("t5_err_cnt", err_cnt_o, 0);
      check("t5_orphan", orphan_o, 0);

      // T6: orphan data while idle, then reset in mid-burst with an error in flight
      rd_word(fill(8'h00));
      check("t6_orphan", orphan_o, 1);
      cyc(); cyc();
      check("t6_orphan_sticky", orphan_o, 1);
      check("t6_err_cnt", err_cnt_o, 0);
      push_cmd(31'h500, 8'd3, 4'd0, 4'd15, 8'h22, 1'b0);
      cyc(); cyc();
      rd_word(fill(8'h00));
      rst_i = 1'b1;
      cyc();
      rst_i = 1'b0;
      check_cleared("t6_reset");
      cyc(); cyc(); cyc();
      check("t6_post_reset_cnt", err_cnt_o, 0);

      check("pending_expected", 64'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
